uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART transmitter among N requesters. It captures a requester's byte and parity configuration, then issues a single-cycle data_valid strobe to the UART TX. It tracks the UART busy flag through the whole frame before granting the next requester. It sits between the client blocks and the UART TX top, and drives all of the UART's input-side control.

---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters.
// A winner's payload and parity settings are captured on the grant, a single
// data_valid strobe is issued, and the UART busy flag is tracked through the
// whole frame before the next grant. Frames whose busy never rises are
// abandoned after BUSY_TMO cycles.
//
// Ports:
//   CLK, RST     clock (rising edge) and asynchronous active-low reset
//   req          per-requester request level, held until granted
//   req_data     flattened payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_par_en   per-requester parity enable
//   req_par_typ  per-requester parity type (1 = odd, 0 = even)
//   busy         UART TX busy flag
//   gnt          one-hot single-cycle grant pulse (payload capture)
//   P_DATA       payload to the UART
//   data_valid   single-cycle strobe to the UART
//   party_en     parity enable to the UART
//   party_typ    parity type to the UART
//   cur_id       index of the last granted requester
//   frame_done   one-cycle pulse when busy falls after a frame
//   tmo_err      one-cycle pulse when busy fails to rise in time
module uart_tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned BUSY_TMO   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]              req_par_en,
  input  logic [N_REQ-1:0]              req_par_typ,
  input  logic                          busy,
  output logic [N_REQ-1:0]              gnt,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          data_valid,
  output logic                          party_en,
  output logic                          party_typ,
  output logic [$clog2(N_REQ)-1:0]      cur_id,
  output logic                          frame_done,
  output logic                          tmo_err
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(BUSY_TMO + 1);

  localparam logic [N_REQ-1:0] GntBase  = N_REQ'(1);
  localparam logic [IdW-1:0]   LastRst  = IdW'(N_REQ - 1);
  localparam logic [CntW-1:0]  TmoLast  = CntW'(BUSY_TMO - 1);
  localparam logic [CntW-1:0]  CntMax   = {CntW{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e           state_q;
  logic [IdW-1:0]   last_q;
  logic [CntW-1:0]  cnt_q;

  logic             win_vld;
  logic [IdW-1:0]   win_id;
  logic [IdW-1:0]   cand;

  // Search upward from the slot after the last served requester, wrapping
  // around, so the most recently served requester is considered last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IdW'((32'(last_q) + off) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      last_q     <= LastRst;
      cnt_q      <= '0;
      gnt        <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      party_en   <= 1'b0;
      party_typ  <= 1'b0;
      cur_id     <= '0;
      frame_done <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      gnt        <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      tmo_err    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A busy UART (e.g. still shifting a frame) blocks any new grant.
          if (!busy && win_vld) begin
            gnt       <= GntBase << win_id;
            P_DATA    <= req_data[32'(win_id)*DATA_WIDTH +: DATA_WIDTH];
            party_en  <= req_par_en[win_id];
            party_typ <= req_par_typ[win_id];
            cur_id    <= win_id;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          data_valid <= 1'b1;
          cnt_q      <= '0;
          state_q    <= StWaitBusy;
        end
        StWaitBusy: begin
          if (busy) begin
            state_q <= StWaitDone;
          end else if (cnt_q == TmoLast) begin
            // Advance the pointer anyway so a dead frame cannot starve others.
            tmo_err <= 1'b1;
            last_q  <= cur_id;
            state_q <= StIdle;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          // Any low level on busy, including a glitch, ends the frame.
          if (!busy) begin
            frame_done <= 1'b1;
            last_q     <= cur_id;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
